// File: rtl/scan_window_sequencer.sv
// Frame scan sequencer: clears vj_pipeline, walks a WIN x WIN window over every
// scannable pyramid level, then drains the pipeline and pulses frame_done.
//
// state | meaning
// IDLE  | waiting for start, face_count held
// CLEAR | one-cycle vj_pipeline reset
// SCAN  | presenting windows, one per unstalled cycle
// DRAIN | PIPE_DEPTH enabled cycles to flush the last window
// DONE  | frame_done pulse
module scan_window_sequencer #(
  parameter int NUM_LEVELS = 13,
  parameter int WIN        = 24,
  parameter int STEP       = 1,
  parameter int PIPE_DEPTH = 2914,
  parameter int DIM_W      = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        stall,
  input  logic [NUM_LEVELS*DIM_W-1:0] level_widths,
  input  logic [NUM_LEVELS*DIM_W-1:0] level_heights,
  input  logic                        face_found,
  output logic [3:0]                  img_index,
  output logic [31:0]                 row_index,
  output logic [31:0]                 col_index,
  output logic                        vj_enable,
  output logic                        vj_reset,
  output logic                        window_valid,
  output logic                        busy,
  output logic                        frame_done,
  output logic [15:0]                 face_count
);

  localparam logic [31:0] WIN_U  = 32'(WIN);
  localparam logic [31:0] STEP_U = 32'(STEP);
  localparam logic [31:0] PIPE_U = 32'(PIPE_DEPTH);

  typedef enum logic [2:0] {IDLE, CLEAR, SCAN, DRAIN, DONE} state_t;

  state_t                  state;
  logic [31:0]             drain_cnt;
  logic [NUM_LEVELS-1:0]   scannable;
  logic [31:0]             cur_w;
  logic [31:0]             cur_h;
  logic                    first_found;
  logic [3:0]              first_level;
  logic                    next_found;
  logic [3:0]              next_level;
  logic                    col_last;
  logic                    row_last;

  // Skip-search over the live level table so level hops cost no bubble cycle.
  always_comb begin
    scannable   = '0;
    cur_w       = '0;
    cur_h       = '0;
    first_found = 1'b0;
    first_level = '0;
    next_found  = 1'b0;
    next_level  = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      scannable[i] = (32'(level_widths[i*DIM_W +: DIM_W]) >= WIN_U) &&
                     (32'(level_heights[i*DIM_W +: DIM_W]) >= WIN_U);
      if (i == int'(img_index)) begin
        cur_w = 32'(level_widths[i*DIM_W +: DIM_W]);
        cur_h = 32'(level_heights[i*DIM_W +: DIM_W]);
      end
    end
    for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
      if (scannable[i]) begin
        first_found = 1'b1;
        first_level = 4'(i);
      end
      if (scannable[i] && (i > int'(img_index))) begin
        next_found = 1'b1;
        next_level = 4'(i);
      end
    end
  end

  assign col_last = (col_index + STEP_U) > (cur_w - WIN_U);
  assign row_last = (row_index + STEP_U) > (cur_h - WIN_U);

  // stall is sampled at the edge and gates the following cycle's registered enables.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      drain_cnt    <= '0;
      img_index    <= '0;
      row_index    <= '0;
      col_index    <= '0;
      vj_enable    <= 1'b0;
      vj_reset     <= 1'b0;
      window_valid <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      face_count   <= '0;
    end else begin
      vj_reset   <= 1'b0;
      frame_done <= 1'b0;
      if (state != IDLE && face_found && face_count != 16'hFFFF)
        face_count <= face_count + 16'd1;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= CLEAR;
            busy         <= 1'b1;
            vj_reset     <= 1'b1;
            vj_enable    <= 1'b0;
            window_valid <= 1'b0;
            face_count   <= '0;
            img_index    <= '0;
            row_index    <= '0;
            col_index    <= '0;
          end
        end
        CLEAR: begin
          vj_enable <= !stall;
          if (first_found) begin
            state        <= SCAN;
            window_valid <= !stall;
            img_index    <= first_level;
          end else begin
            state     <= DRAIN;
            drain_cnt <= PIPE_U;
          end
        end
        SCAN: begin
          vj_enable    <= !stall;
          window_valid <= !stall;
          if (window_valid) begin
            if (!col_last) begin
              col_index <= col_index + STEP_U;
            end else if (!row_last) begin
              col_index <= '0;
              row_index <= row_index + STEP_U;
            end else if (next_found) begin
              img_index <= next_level;
              row_index <= '0;
              col_index <= '0;
            end else begin
              state        <= DRAIN;
              drain_cnt    <= PIPE_U;
              window_valid <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (vj_enable && drain_cnt <= 32'd1) begin
            state      <= DONE;
            vj_enable  <= 1'b0;
            frame_done <= 1'b1;
            drain_cnt  <= '0;
          end else begin
            vj_enable <= !stall;
            if (vj_enable)
              drain_cnt <= drain_cnt - 32'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_window_sequencer.sv
// Bench for scan_window_sequencer (2 levels, PIPE_DEPTH 4): directed vector table,
// hand-written corner sequences and randomized frames against a window-list model.
module tb_scan_window_sequencer;

  localparam int NL   = 2;
  localparam int WIN  = 24;
  localparam int PD   = 4;
  localparam int MAXC = 512;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        face_found = 1'b0;
  logic [31:0] level_widths = '0;
  logic [31:0] level_heights = '0;
  logic [3:0]  img_index;
  logic [31:0] row_index;
  logic [31:0] col_index;
  logic        vj_enable;
  logic        vj_reset;
  logic        window_valid;
  logic        busy;
  logic        frame_done;
  logic [15:0] face_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  scan_window_sequencer #(
    .NUM_LEVELS(NL), .WIN(WIN), .STEP(1), .PIPE_DEPTH(PD), .DIM_W(16)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .stall(stall),
    .level_widths(level_widths), .level_heights(level_heights),
    .face_found(face_found), .img_index(img_index), .row_index(row_index),
    .col_index(col_index), .vj_enable(vj_enable), .vj_reset(vj_reset),
    .window_valid(window_valid), .busy(busy), .frame_done(frame_done),
    .face_count(face_count)
  );

  // Plans are indexed by the cycle during which the value is driven.
  logic stall_plan [MAXC];
  logic face_plan  [MAXC];
  logic start_plan [MAXC];
  logic obs_valid  [MAXC];
  logic obs_en     [MAXC];
  logic obs_rst    [MAXC];
  logic obs_busy   [MAXC];
  logic obs_done   [MAXC];
  int   obs_img    [MAXC];
  int   obs_row    [MAXC];
  int   obs_col    [MAXC];
  int   obs_fc     [MAXC];
  int   done_cyc;
  int   last_cyc;
  int   lw [NL];
  int   lh [NL];

  typedef struct {
    int w0, h0, w1, h1;
    int s0, s1, s2;
    int exp_win;
    int exp_done;
  } vec_t;
  vec_t vecs [7];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input bit ok, input string name, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  task automatic set_dims(input int w0, input int h0, input int w1, input int h1);
    lw[0] = w0; lh[0] = h0; lw[1] = w1; lh[1] = h1;
    level_widths  = {16'(w1), 16'(w0)};
    level_heights = {16'(h1), 16'(h0)};
  endtask

  task automatic clear_plans();
    for (int k = 0; k < MAXC; k++) begin
      stall_plan[k] = 1'b0;
      face_plan[k]  = 1'b0;
      start_plan[k] = 1'b0;
    end
  endtask

  // Pulses start in cycle 0 and records every cycle up to the one after frame_done.
  task automatic run_frame();
    done_cyc   = -1;
    last_cyc   = 0;
    start      = 1'b1;
    stall      = stall_plan[0];
    face_found = face_plan[0];
    tick();
    for (int cyc = 1; cyc < MAXC; cyc++) begin
      obs_valid[cyc] = window_valid;
      obs_en[cyc]    = vj_enable;
      obs_rst[cyc]   = vj_reset;
      obs_busy[cyc]  = busy;
      obs_done[cyc]  = frame_done;
      obs_img[cyc]   = int'(img_index);
      obs_row[cyc]   = int'(row_index);
      obs_col[cyc]   = int'(col_index);
      obs_fc[cyc]    = int'(face_count);
      last_cyc       = cyc;
      if (frame_done && done_cyc < 0) done_cyc = cyc;
      if (done_cyc >= 0 && cyc == done_cyc + 1) break;
      if (cyc == MAXC - 1) break;
      start      = start_plan[cyc];
      stall      = stall_plan[cyc];
      face_found = face_plan[cyc];
      tick();
    end
    start = 1'b0; stall = 1'b0; face_found = 1'b0;
    check(done_cyc >= 0, "frame_timeout", $sformatf("frame_done seen=%0d, wanted within %0d cycles", done_cyc >= 0, MAXC));
  endtask

  // Reference: list every window from the level table, then consume one per unstalled
  // cycle, then count PD unstalled drain cycles, then one DONE cycle.
  task automatic check_model(input string tag);
    int qi[$], qr[$], qc[$];
    int n, pos, drained, exp_done, fc, ei, er, ec;
    logic ev, een, erst, ebusy, edone;
    bit ok;
    for (int lv = 0; lv < NL; lv++)
      if (lw[lv] >= WIN && lh[lv] >= WIN)
        for (int r = 0; r <= lh[lv] - WIN; r++)
          for (int c = 0; c <= lw[lv] - WIN; c++) begin
            qi.push_back(lv); qr.push_back(r); qc.push_back(c);
          end
    n = qi.size(); pos = 0; drained = 0; exp_done = -1; fc = 0;
    ei = 0; er = 0; ec = 0;
    for (int k = 1; k < MAXC - 1; k++) begin
      if (k >= 2 && face_plan[k-1]) fc++;
      ebusy = 1'b1; erst = 1'b0; edone = 1'b0; ev = 1'b0; een = 1'b0;
      if (k == 1) begin
        erst = 1'b1;
      end else if (exp_done >= 0) begin
        ebusy = 1'b0;
      end else if (pos < n) begin
        ei = qi[pos]; er = qr[pos]; ec = qc[pos];
        ev = !stall_plan[k-1];
        een = ev;
        if (een) pos++;
      end else if (drained < PD) begin
        een = !stall_plan[k-1];
        if (een) drained++;
      end else begin
        edone = 1'b1;
        exp_done = k;
      end
      if (k > last_cyc) begin
        check(1'b0, {tag, "_length"}, $sformatf("recording ended at cycle %0d, model still running at %0d", last_cyc, k));
        break;
      end
      ok = obs_valid[k] == ev && obs_en[k] == een && obs_rst[k] == erst &&
           obs_busy[k] == ebusy && obs_done[k] == edone && obs_img[k] == ei &&
           obs_row[k] == er && obs_col[k] == ec && obs_fc[k] == fc;
      check(ok, {tag, "_cycle"}, $sformatf(
        "cyc %0d got v%0d e%0d r%0d b%0d d%0d (%0d,%0d,%0d) fc%0d, wanted v%0d e%0d r%0d b%0d d%0d (%0d,%0d,%0d) fc%0d",
        k, obs_valid[k], obs_en[k], obs_rst[k], obs_busy[k], obs_done[k], obs_img[k], obs_row[k], obs_col[k], obs_fc[k],
        ev, een, erst, ebusy, edone, ei, er, ec, fc));
      if (exp_done >= 0 && k == exp_done + 1) break;
    end
    check(done_cyc == exp_done, {tag, "_done_cycle"}, $sformatf("got %0d, wanted %0d", done_cyc, exp_done));
  endtask

  function automatic int count_valid();
    int s = 0;
    for (int k = 1; k <= last_cyc; k++) if (obs_valid[k]) s++;
    return s;
  endfunction

  function automatic int count_en();
    int s = 0;
    for (int k = 1; k <= last_cyc; k++) if (obs_en[k]) s++;
    return s;
  endfunction

  initial begin
    int exp_rc [6][2];
    int n_v;
    bit got;

    vecs[0] = '{26, 25, 20, 30, -1, -1, -1, 6, 12};
    vecs[1] = '{26, 25, 20, 30,  3,  4,  8, 6, 15};
    vecs[2] = '{24, 24, 25, 24, -1, -1, -1, 3,  9};
    vecs[3] = '{10, 10, 10, 10, -1, -1, -1, 0,  6};
    vecs[4] = '{20, 30, 26, 25, -1, -1, -1, 6, 12};
    vecs[5] = '{24, 24, 24, 24,  1, -1, -1, 2,  9};
    vecs[6] = '{26, 25, 20, 30,  6, -1, -1, 6, 13};
    exp_rc = '{'{0, 0}, '{0, 1}, '{0, 2}, '{1, 0}, '{1, 1}, '{1, 2}};

    reset = 1'b1;
    tick();
    check(busy == 1'b0 && vj_enable == 1'b0 && vj_reset == 1'b0 && window_valid == 1'b0 &&
          frame_done == 1'b0 && face_count == 16'd0 && img_index == 4'd0 &&
          row_index == 32'd0 && col_index == 32'd0, "reset_state",
          $sformatf("busy %0d en %0d rst %0d v %0d done %0d fc %0d idx (%0d,%0d,%0d), wanted all 0",
                    busy, vj_enable, vj_reset, window_valid, frame_done, face_count, img_index, row_index, col_index));
    tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      clear_plans();
      set_dims(vecs[i].w0, vecs[i].h0, vecs[i].w1, vecs[i].h1);
      if (vecs[i].s0 >= 0) stall_plan[vecs[i].s0] = 1'b1;
      if (vecs[i].s1 >= 0) stall_plan[vecs[i].s1] = 1'b1;
      if (vecs[i].s2 >= 0) stall_plan[vecs[i].s2] = 1'b1;
      run_frame();
      check(count_valid() == vecs[i].exp_win, "vec_windows", $sformatf("vec %0d got %0d, wanted %0d", i, count_valid(), vecs[i].exp_win));
      check(count_en() == vecs[i].exp_win + PD, "vec_enables", $sformatf("vec %0d got %0d, wanted %0d", i, count_en(), vecs[i].exp_win + PD));
      check(done_cyc == vecs[i].exp_done, "vec_done", $sformatf("vec %0d got %0d, wanted %0d", i, done_cyc, vecs[i].exp_done));
      check_model($sformatf("vec%0d", i));
      if (i == 0) begin
        for (int j = 0; j < 6; j++)
          check(obs_valid[2+j] && obs_img[2+j] == 0 && obs_row[2+j] == exp_rc[j][0] && obs_col[2+j] == exp_rc[j][1],
                "seq_26x25", $sformatf("cyc %0d got v%0d (%0d,%0d,%0d), wanted v1 (0,%0d,%0d)",
                2+j, obs_valid[2+j], obs_img[2+j], obs_row[2+j], obs_col[2+j], exp_rc[j][0], exp_rc[j][1]));
        check(obs_rst[1] == 1'b1 && obs_busy[13] == 1'b0, "clear_and_idle",
              $sformatf("vj_reset@1 %0d busy@13 %0d, wanted 1 and 0", obs_rst[1], obs_busy[13]));
      end
      if (i == 1)
        check(obs_row[4] == 0 && obs_col[4] == 2 && obs_row[5] == 0 && obs_col[5] == 2 && !obs_en[4] && !obs_en[5],
              "stall_hold", $sformatf("c4 (%0d,%0d) e%0d c5 (%0d,%0d) e%0d, wanted (0,2) e0 twice",
              obs_row[4], obs_col[4], obs_en[4], obs_row[5], obs_col[5], obs_en[5]));
      if (i == 2)
        check(obs_valid[2] && obs_valid[3] && obs_valid[4] && obs_img[2] == 0 && obs_img[3] == 1 && obs_img[4] == 1 &&
              obs_col[3] == 0 && obs_col[4] == 1, "level_hop",
              $sformatf("v %0d%0d%0d img %0d%0d%0d col %0d %0d, wanted v111 img 011 col 0 1",
              obs_valid[2], obs_valid[3], obs_valid[4], obs_img[2], obs_img[3], obs_img[4], obs_col[3], obs_col[4]));
      tick();
    end

    // Face counting across a frame, clear on the next start, start ignored while busy.
    clear_plans();
    set_dims(26, 25, 20, 30);
    face_plan[3] = 1'b1; face_plan[6] = 1'b1; face_plan[10] = 1'b1;
    run_frame();
    check(obs_fc[last_cyc] == 3, "face_count", $sformatf("got %0d, wanted 3", obs_fc[last_cyc]));
    check_model("faces");
    tick();
    check(face_count == 16'd3, "face_hold_idle", $sformatf("got %0d, wanted 3", face_count));
    clear_plans();
    start_plan[4] = 1'b1;
    run_frame();
    check(obs_fc[1] == 0, "face_clear", $sformatf("got %0d, wanted 0", obs_fc[1]));
    check(done_cyc == 12 && count_valid() == 6, "start_while_busy",
          $sformatf("done %0d windows %0d, wanted 12 and 6", done_cyc, count_valid()));
    check_model("restart");
    tick();

    // Asynchronous reset at window (1,1).
    clear_plans();
    set_dims(26, 25, 20, 30);
    start = 1'b1;
    tick();
    start = 1'b0;
    face_found = 1'b1;
    tick();
    face_found = 1'b0;
    repeat (4) tick();
    check(window_valid && row_index == 32'd1 && col_index == 32'd1, "pre_reset_pos",
          $sformatf("got v%0d (%0d,%0d), wanted v1 (1,1)", window_valid, row_index, col_index));
    #2 reset = 1'b1;
    #1;
    check(busy == 1'b0 && vj_enable == 1'b0 && vj_reset == 1'b0 && window_valid == 1'b0 &&
          frame_done == 1'b0 && face_count == 16'd0 && img_index == 4'd0 &&
          row_index == 32'd0 && col_index == 32'd0, "async_reset",
          $sformatf("busy %0d en %0d v %0d fc %0d idx (%0d,%0d,%0d), wanted all 0",
                    busy, vj_enable, window_valid, face_count, img_index, row_index, col_index));
    tick(); tick();
    reset = 1'b0;
    tick();
    run_frame();
    check(count_valid() == 6 && done_cyc == 12, "rerun_after_reset",
          $sformatf("windows %0d done %0d, wanted 6 and 12", count_valid(), done_cyc));
    check_model("rerun");
    tick();

    // Randomized frames against the model.
    for (int it = 0; it < 24; it++) begin
      clear_plans();
      set_dims($urandom_range(18, 28), $urandom_range(18, 28), $urandom_range(18, 28), $urandom_range(18, 28));
      for (int k = 0; k < MAXC; k++) begin
        stall_plan[k] = ($urandom_range(0, 3) == 0);
        face_plan[k]  = ($urandom_range(0, 4) == 0);
        start_plan[k] = (k > 0) && ($urandom_range(0, 15) == 0);
      end
      run_frame();
      check_model($sformatf("rand%0d", it));
      tick();
    end

    // Saturation: hold the scan stalled while face_found stays high.
    clear_plans();
    set_dims(26, 25, 20, 30);
    start = 1'b1;
    stall = 1'b1;
    tick();
    start = 1'b0;
    face_found = 1'b1;
    repeat (65540) tick();
    check(face_count == 16'hFFFF && busy, "face_saturate", $sformatf("got %0h busy %0d, wanted ffff busy 1", face_count, busy));
    face_found = 1'b0;
    stall = 1'b0;
    got = 1'b0;
    n_v = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      if (window_valid) n_v++;
      if (frame_done) got = 1'b1;
    end
    check(got && n_v == 6, "saturate_finish", $sformatf("done %0d windows %0d, wanted 1 and 6", got, n_v));
    tick();
    check(face_count == 16'hFFFF && !busy, "saturate_idle", $sformatf("got %0h busy %0d, wanted ffff busy 0", face_count, busy));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
